seg_display_arbiter: RTL and testbench

- Shares the single 4-digit 7-segment display between three requesters: game score, keyboard scancode debug, and status/alert message.
- Picks one owner by fixed priority, enforces a minimum ownership time, and inserts one blank scan period on every owner change.
- Drives the digit-scan multiplex and hex decode for the current owner.
- Sits between the game-logic blocks and the board's seg/an pins.

---
 rtl/seg_display_arbiter.sv | 149 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: fixed-priority owner of a shared 4-digit 7-segment display with min hold and blank-slot handover.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (3..1) of the owner's value.
module seg_display_arbiter #(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [3:0]  den0,
  input  logic [3:0]  den1,
  input  logic [3:0]  den2,
  output logic [2:0]  grant,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;
  state_t state, state_nx;
  logic [SW-1:0] scan_cnt;
  logic [1:0] dig;
  logic [HW-1:0] hold, hold_nx;
  logic armed, armed_nx;
  logic [2:0] grant_nx, pick;
  logic tick, owner_req, preempt;
  logic [15:0] d;
  logic [3:0] en, lz;
  logic [3:0] nib;
  logic lit;
  logic [3:0] an_nx;
  logic [6:0] seg_nx;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick = scan_cnt == SW'(SCAN_DIV - 1);
  assign pick = req & (~req + 3'd1);
  assign owner_req = |(req & grant);
  assign preempt = |(req & (grant - 3'd1)) && hold == '0;

  // Free-running scan timer and digit index, active in every state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_cnt <= '0;
      dig <= 2'd0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + SW'(1);
      dig <= tick ? dig + 2'd1 : dig;
    end
  end

  // Ownership state, hold timer and registered grant
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      grant <= 3'b000;
      hold <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      hold <= hold_nx;
      armed <= armed_nx;
    end
  end

  // Arbitration: grant lowest set req, release on drop, preempt only after hold expires; SWITCH lasts to its second tick
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    hold_nx = hold;
    armed_nx = armed;
    case (state)
      IDLE: if (|req) begin
        grant_nx = pick;
        hold_nx = HW'(HOLD_CYCLES);
        state_nx = OWN;
      end
      OWN: begin
        hold_nx = hold == '0 ? '0 : hold - HW'(1);
        if (!owner_req || preempt) begin
          grant_nx = 3'b000;
          armed_nx = 1'b0;
          state_nx = SWITCH;
        end
      end
      SWITCH: if (tick) begin
        armed_nx = 1'b1;
        if (armed) begin
          grant_nx = pick;
          hold_nx = HW'(HOLD_CYCLES);
          state_nx = |req ? OWN : IDLE;
        end
      end
      default: begin
        grant_nx = 3'b000;
        state_nx = IDLE;
      end
    endcase
  end

  // Select the owner's live data and digit enables, decide whether the current digit lights
  always_comb begin
    d = grant[0] ? data0 : grant[1] ? data1 : data2;
    en = grant[0] ? den0 : grant[1] ? den1 : den2;
`ifdef LEADING_ZERO_BLANK_EN
    lz = {d[15:12] == 4'h0, d[15:8] == 8'h0, d[15:4] == 12'h0, 1'b0};
`else
    lz = 4'b0000;
`endif
    nib = d[{dig, 2'b00} +: 4];
    lit = state == OWN && en[dig] && !lz[dig];
    an_nx = lit ? ~(4'b0001 << dig) : 4'b1111;
    seg_nx = lit ? hex7(nib) : 7'b1111111;
  end

  // Registered display drive
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      an <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an <= an_nx;
      seg <= seg_nx;
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed + random stimulus checked against a cycle-count based reference model.
module tb_seg_display_arbiter;
  localparam int S = 4;
  localparam int H = 20;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [2:0] req = 3'b000;
  logic [15:0] data0 = '0, data1 = '0, data2 = '0;
  logic [3:0] den0 = '0, den1 = '0, den2 = '0;
  logic [2:0] grant;
  logic [6:0] seg;
  logic [3:0] an;
  int n_tests = 0;
  int n_fail = 0;
  logic [6:0] hexd [16];
  int cyc, m_state, m_owner, m_gcyc, m_swt;
  logic [2:0] e_grant;
  logic [3:0] e_an;
  logic [6:0] e_seg;

  always #5 CLK = ~CLK;

  seg_display_arbiter #(.SCAN_DIV(S), .HOLD_CYCLES(H)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .den0(den0), .den1(den1), .den2(den2),
    .grant(grant), .seg(seg), .an(an)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [2:0] r);
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_state = 0;
    m_owner = -1;
    m_gcyc = 0;
    m_swt = 0;
    e_grant = 3'b000;
    e_an = 4'b1111;
    e_seg = 7'b1111111;
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic step();
    int dg;
    bit tk, lt;
    logic [15:0] dd;
    logic [3:0] ee;
    tk = (cyc % S) == S - 1;
    dg = (cyc / S) % 4;
    e_an = 4'b1111;
    e_seg = 7'b1111111;
    if (m_state == 1) begin
      dd = m_owner == 0 ? data0 : m_owner == 1 ? data1 : data2;
      ee = m_owner == 0 ? den0 : m_owner == 1 ? den1 : den2;
      lt = ee[dg];
`ifdef LEADING_ZERO_BLANK_EN
      if (dg > 0 && (dd >> (4 * dg)) == 16'h0) lt = 0;
`endif
      if (lt) begin
        e_an = ~(4'b0001 << dg);
        e_seg = hexd[int'((dd >> (4 * dg)) & 16'hf)];
      end
    end
    case (m_state)
      0: if (req != 0) begin
        m_owner = lowest(req);
        m_gcyc = cyc + 1;
        m_state = 1;
      end
      1: if (!req[m_owner] || ((int'(req) % (1 << m_owner)) != 0 && cyc - m_gcyc >= H)) begin
        m_state = 2;
        m_swt = 0;
      end
      default: if (tk) begin
        m_swt++;
        if (m_swt == 2) begin
          if (req != 0) begin
            m_owner = lowest(req);
            m_gcyc = cyc + 1;
            m_state = 1;
          end else m_state = 0;
        end
      end
    endcase
    e_grant = m_state == 1 ? 3'(1 << m_owner) : 3'b000;
    cyc++;
  endtask

  task automatic run(input logic [2:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      req = r;
      step();
      @(negedge CLK);
      check("grant", 16'(grant), 16'(e_grant));
      check("an", 16'(an), 16'(e_an));
      check("seg", 16'(seg), 16'(e_seg));
    end
  endtask

  initial begin
    hexd[0] = 7'b1000000; hexd[1] = 7'b1111001; hexd[2] = 7'b0100100; hexd[3] = 7'b0110000;
    hexd[4] = 7'b0011001; hexd[5] = 7'b0010010; hexd[6] = 7'b0000010; hexd[7] = 7'b1111000;
    hexd[8] = 7'b0000000; hexd[9] = 7'b0010000; hexd[10] = 7'b0001000; hexd[11] = 7'b0000011;
    hexd[12] = 7'b1000110; hexd[13] = 7'b0100001; hexd[14] = 7'b0000110; hexd[15] = 7'b0001110;
    model_reset();
    req = 3'b001;
    repeat (3) @(negedge CLK);
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_an", 16'(an), 16'hf);
    check("rst_seg", 16'(seg), 16'h7f);
    req = 3'b000;
    RST_N = 1'b1;
    run(3'b000, 6);
    data0 = 16'h12AB;
    den0 = 4'hf;
    run(3'b001, 24);
    if (m_state == 1) begin
      #2 RST_N = 1'b0;
      #1;
      check("async_grant", 16'(grant), 16'h0);
      check("async_an", 16'(an), 16'hf);
      check("async_seg", 16'(seg), 16'h7f);
      @(negedge CLK);
      RST_N = 1'b1;
      model_reset();
    end else check("own_before_reset", 16'(m_state), 16'd1);
    run(3'b000, 7);
    data1 = 16'hC0DE;
    den1 = 4'hf;
    run(3'b010, 5);
    run(3'b011, 40);
    run(3'b001, 6);
    run(3'b110, 20);
    run(3'b000, 15);
    run(3'b111, 5);
    run(3'b101, 30);
    data2 = 16'h00F0;
    den2 = 4'b1011;
    run(3'b100, 30);
    data0 = 16'h0005;
    den0 = 4'hf;
    run(3'b101, 50);
    run(3'b001, 20);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) req = 3'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        data0 = 16'($urandom) >> $urandom_range(0, 15);
        data1 = 16'($urandom) >> $urandom_range(0, 15);
        data2 = 16'($urandom) >> $urandom_range(0, 15);
        den0 = 4'($urandom);
        den1 = 4'($urandom);
        den2 = 4'($urandom);
      end
      run(req, 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
